// File: rtl/matmul_tile_scheduler.sv
// Tile-grid sequencer for the accumulator array: issues (row,col,k) operand fetches under
// a credit limit, gates partial products into the array and tags finished tiles with coordinates.
module matmul_tile_scheduler #(
    parameter int ACC_DEPTH       = 4,
    parameter int MAX_M           = 16,
    parameter int MAX_N           = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int MW              = $clog2(MAX_M + 1),
    parameter int NW              = $clog2(MAX_N + 1),
    parameter int KW              = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic [MW-1:0] cfg_m,
    input  logic [NW-1:0] cfg_n,
    output logic          busy,
    output logic          done,
    output logic          req_valid,
    input  logic          req_ready,
    output logic [MW-1:0] req_row,
    output logic [NW-1:0] req_col,
    output logic [KW-1:0] req_k,
    output logic          req_last,
    input  logic          prod_valid,
    output logic          prod_ready,
    output logic          acc_in_valid,
    input  logic          acc_in_ready,
    input  logic          acc_out_valid,
    output logic          acc_out_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] out_row,
    output logic [NW-1:0] out_col,
    output logic          out_last
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [MW-1:0] m_q, row, o_row;
    logic [NW-1:0] n_q, col, o_col;
    logic [KW-1:0] k;
    logic [CW-1:0] credits;

    logic active, req_hs, prod_hs, out_hs;
    logic k_wrap, col_wrap, row_wrap, zero_job;

    assign active   = (state == RUN) || (state == DRAIN);
    assign zero_job = (cfg_m == '0) || (cfg_n == '0);

    assign start_ready   = (state == IDLE);
    assign busy          = active;
    assign done          = (state == DONE);
    assign req_valid     = (state == RUN) && (credits < CW'(MAX_OUTSTANDING));
    assign req_row       = row;
    assign req_col       = col;
    assign req_k         = k;
    assign prod_ready    = acc_in_ready & active;
    assign acc_in_valid  = prod_valid & active;
    assign acc_out_ready = out_ready;
    assign out_valid     = acc_out_valid & active;
    assign out_row       = o_row;
    assign out_col       = o_col;

    assign k_wrap   = (k == KW'(ACC_DEPTH - 1));
    assign col_wrap = (col == n_q - NW'(1));
    assign row_wrap = (row == m_q - MW'(1));
    assign req_last = k_wrap;
    assign out_last = (o_row == m_q - MW'(1)) && (o_col == n_q - NW'(1));

    assign req_hs  = req_valid & req_ready;
    assign prod_hs = prod_valid & prod_ready;
    assign out_hs  = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_valid) state_nxt = zero_job ? DONE : RUN;
            // Final tile leaving wins over the last-request transition in the same cycle.
            RUN: begin
                if (out_hs && out_last)
                    state_nxt = DONE;
                else if (req_hs && k_wrap && col_wrap && row_wrap)
                    state_nxt = DRAIN;
            end
            DRAIN: if (out_hs && out_last) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            m_q     <= '0;
            n_q     <= '0;
            row     <= '0;
            col     <= '0;
            k       <= '0;
            o_row   <= '0;
            o_col   <= '0;
            credits <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start_valid) begin
                m_q     <= cfg_m;
                n_q     <= cfg_n;
                row     <= '0;
                col     <= '0;
                k       <= '0;
                o_row   <= '0;
                o_col   <= '0;
                credits <= '0;
            end else begin
                if (req_hs) begin
                    if (k_wrap) begin
                        k <= '0;
                        if (col_wrap) begin
                            col <= '0;
                            row <= row + MW'(1);
                        end else begin
                            col <= col + NW'(1);
                        end
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                if (out_hs) begin
                    if (o_col == n_q - NW'(1)) begin
                        o_col <= '0;
                        o_row <= o_row + MW'(1);
                    end else begin
                        o_col <= o_col + NW'(1);
                    end
                end
                if (req_hs && !prod_hs)
                    credits <= credits + CW'(1);
                else if (!req_hs && prod_hs && credits != '0)
                    credits <= credits - CW'(1);
            end
        end
    end

`ifndef SYNTHESIS
    // A product with no fetch in flight means the datapath broke protocol.
    a_no_orphan_prod: assert property (@(posedge clk) disable iff (!rst)
        prod_hs |-> (credits != '0));
`endif

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Randomized bench for matmul_tile_scheduler: a loop-nest reference model of request and
// tile order, plus a small datapath/accumulator environment that closes the product loop.
module tb_matmul_tile_scheduler;
    localparam int ACC_DEPTH = 4;
    localparam int MAX_M     = 16;
    localparam int MAX_N     = 16;
    localparam int MAX_OUT   = 4;
    localparam int MW        = $clog2(MAX_M + 1);
    localparam int NW        = $clog2(MAX_N + 1);
    localparam int KW        = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;

    logic          clk, rst;
    logic          start_valid, start_ready, busy, done;
    logic [MW-1:0] cfg_m, req_row, out_row;
    logic [NW-1:0] cfg_n, req_col, out_col;
    logic [KW-1:0] req_k;
    logic          req_valid, req_ready, req_last;
    logic          prod_valid, prod_ready, acc_in_valid, acc_in_ready;
    logic          acc_out_valid, acc_out_ready, out_valid, out_ready, out_last;

    matmul_tile_scheduler #(
        .ACC_DEPTH(ACC_DEPTH), .MAX_M(MAX_M), .MAX_N(MAX_N), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .cfg_m(cfg_m), .cfg_n(cfg_n), .busy(busy), .done(done),
        .req_valid(req_valid), .req_ready(req_ready), .req_row(req_row),
        .req_col(req_col), .req_k(req_k), .req_last(req_last),
        .prod_valid(prod_valid), .prod_ready(prod_ready),
        .acc_in_valid(acc_in_valid), .acc_in_ready(acc_in_ready),
        .acc_out_valid(acc_out_valid), .acc_out_ready(acc_out_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_col(out_col), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ptag(input int r, input int c, input int kk);
        return (r << 16) | (c << 8) | kk;
    endfunction

    // reference model and environment state
    int exp_req[$];
    int exp_out[$];
    int pend, acc_cnt, tiles, n_req, n_out;
    int p_req, p_prod, p_acc, p_out, p_start;
    bit hold_req, hold_out;
    int hold_req_v, hold_out_v;

    task automatic set_probs(input int a, input int b, input int c, input int d, input int s);
        p_req = a; p_prod = b; p_acc = c; p_out = d; p_start = s;
    endtask

    // One clock: drive at negedge, settle, then account for handshakes the next posedge takes.
    task automatic step();
        int e, cur;
        @(negedge clk);
        req_ready     = ($urandom_range(99) < p_req);
        prod_valid    = (pend > 0) && ($urandom_range(99) < p_prod);
        acc_in_ready  = ($urandom_range(99) < p_acc);
        acc_out_valid = (tiles > 0);
        out_ready     = ($urandom_range(99) < p_out);
        start_valid   = ($urandom_range(99) < p_start);
        cfg_m         = MW'($urandom_range(MAX_M));
        cfg_n         = NW'($urandom_range(MAX_N));
        #1;
        cur = ptag(int'(req_row), int'(req_col), int'(req_k));
        if (hold_req) chk("req_hold", cur, hold_req_v);
        if (hold_out) chk("out_hold", ptag(int'(out_row), int'(out_col), int'(out_last)), hold_out_v);
        chk("credit_cap", 32'(req_valid && (pend >= MAX_OUT)), 0);
        if (req_valid && req_ready) begin
            chk("req_avail", 32'(exp_req.size() > 0), 1);
            if (exp_req.size() > 0) begin
                e = exp_req.pop_front();
                chk("req_tag", cur, e);
                chk("req_last", 32'(req_last), 32'((e & 255) == ACC_DEPTH - 1));
            end
            n_req++;
            pend++;
        end
        if (prod_valid && prod_ready) begin
            pend--;
            acc_cnt++;
            if (acc_cnt == ACC_DEPTH) begin
                acc_cnt = 0;
                tiles++;
            end
        end
        if (out_valid && out_ready) begin
            chk("out_avail", 32'(exp_out.size() > 0), 1);
            if (exp_out.size() > 0) begin
                e = exp_out.pop_front();
                chk("out_tag", ptag(int'(out_row), int'(out_col), 0), e);
                chk("out_last", 32'(out_last), 32'(exp_out.size() == 0));
            end
            tiles--;
            n_out++;
        end
        hold_req   = req_valid && !req_ready;
        hold_req_v = cur;
        hold_out   = out_valid && !out_ready;
        hold_out_v = ptag(int'(out_row), int'(out_col), int'(out_last));
    endtask

    task automatic start_job(input int m, input int n);
        exp_req.delete();
        exp_out.delete();
        for (int r = 0; r < m; r++)
            for (int c = 0; c < n; c++) begin
                exp_out.push_back(ptag(r, c, 0));
                for (int kk = 0; kk < ACC_DEPTH; kk++) exp_req.push_back(ptag(r, c, kk));
            end
        pend = 0; acc_cnt = 0; tiles = 0; n_req = 0; n_out = 0;
        hold_req = 0; hold_out = 0;
        @(negedge clk);
        req_ready = 0; prod_valid = 0; acc_in_ready = 0; acc_out_valid = 0; out_ready = 0;
        start_valid = 1;
        cfg_m = MW'(m);
        cfg_n = NW'(n);
        #1;
        chk("start_ready", 32'(start_ready), 1);
        step();
        chk("first_req", 32'(req_valid), 32'(m > 0 && n > 0));
    endtask

    task automatic finish_job(input int budget);
        int  c = 0;
        bit  seen = 0;
        while (c < budget && !seen) begin
            step();
            if (done) seen = 1;
            c++;
        end
        chk("done_seen", 32'(seen), 1);
        chk("req_left", exp_req.size(), 0);
        chk("out_left", exp_out.size(), 0);
        chk("busy_at_done", 32'(busy), 0);
        p_start = 0;
        start_valid = 0;
        step();
        chk("done_pulse", 32'(done), 0);
        chk("idle_ready", 32'(start_ready), 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int m, n, c;
        rst = 0;
        start_valid = 0; cfg_m = '0; cfg_n = '0; req_ready = 0; prod_valid = 0;
        acc_in_ready = 1; acc_out_valid = 0; out_ready = 0;
        hold_req = 0; hold_out = 0;
        set_probs(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_start_ready", 32'(start_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_req_valid", 32'(req_valid), 0);
        chk("rst_prod_ready", 32'(prod_ready), 0);
        @(negedge clk);
        rst = 1;

        // full-throughput 2x3 job
        set_probs(100, 100, 100, 100, 0);
        start_job(2, 3);
        finish_job(500);
        chk("t1_reqs", n_req, 24);
        chk("t1_outs", n_out, 6);

        // credit cap with products stalled, then one product frees exactly one slot
        set_probs(100, 0, 100, 0, 0);
        start_job(2, 2);
        repeat (8) step();
        chk("cap_reqs", n_req, 4);
        chk("cap_req_valid", 32'(req_valid), 0);
        set_probs(100, 100, 100, 0, 0);
        step();
        set_probs(100, 0, 100, 0, 0);
        repeat (6) step();
        chk("cap_reqs_plus1", n_req, 5);
        set_probs(70, 70, 70, 70, 0);
        finish_job(2000);

        // output backpressure for 10 cycles
        set_probs(100, 100, 100, 0, 0);
        start_job(2, 2);
        c = 0;
        while (!out_valid && c < 200) begin
            step();
            c++;
        end
        chk("bp_out_valid", 32'(out_valid), 1);
        repeat (10) step();
        chk("bp_no_advance", n_out, 0);
        set_probs(100, 100, 100, 100, 0);
        finish_job(500);

        // zero-length job
        set_probs(0, 0, 0, 0, 0);
        start_job(0, 5);
        chk("zero_done", 32'(done), 1);
        chk("zero_out_valid", 32'(out_valid), 0);
        start_valid = 0;
        step();
        chk("zero_done_pulse", 32'(done), 0);
        chk("zero_idle_ready", 32'(start_ready), 1);
        chk("zero_reqs", n_req, 0);

        // randomized jobs with backpressure and ignored mid-job starts
        for (int j = 0; j < 10; j++) begin
            m = $urandom_range(1, 4);
            n = $urandom_range(1, 4);
            set_probs($urandom_range(30, 100), $urandom_range(30, 100),
                      $urandom_range(30, 100), $urandom_range(30, 100), 20);
            start_job(m, n);
            finish_job(5000);
            chk("rnd_reqs", n_req, m * n * ACC_DEPTH);
            chk("rnd_outs", n_out, m * n);
        end

        // reset mid-run with three fetches in flight
        set_probs(100, 0, 100, 0, 0);
        start_job(2, 3);
        repeat (2) step();
        chk("pre_rst_reqs", n_req, 3);
        @(negedge clk);
        start_valid = 0;
        rst = 0;
        #1;
        chk("mid_rst_start_ready", 32'(start_ready), 1);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_req_valid", 32'(req_valid), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_prod_ready", 32'(prod_ready), 0);
        @(negedge clk);
        rst = 1;
        set_probs(100, 100, 100, 100, 0);
        start_job(1, 1);
        finish_job(200);
        chk("post_rst_reqs", n_req, 4);
        chk("post_rst_outs", n_out, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
